// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_sync / fifo_drain pair: default word width,
// drain controller state type and the read-credit helper.
package fifo_pkg;

    localparam int FIFO_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } drain_state_e;

    // A new read may be issued while buffered + in-flight words stay below the
    // 2-entry buffer depth. A word leaving the buffer at this same edge frees
    // its slot in time for the read's data, which lands one edge later.
    function automatic logic credit_avail(input logic [1:0] buffered,
                                          input logic       in_flight,
                                          input logic       leaving);
        logic [2:0] used;
        used = {1'b0, buffered} + {2'b00, in_flight} - {2'b00, leaving};
        return used < 3'd2;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register buffer. head is always the oldest word. A push and a pop
// in the same cycle keep the occupancy unchanged and preserve word order.
module skid_buf2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              do_push;
    logic              do_pop;

    // Next-state of the two entries and the occupancy
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);

        case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = din;
                end else begin
                    tail_d = din;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = din;
                end else begin
                    head_d = tail_q;
                    tail_d = din;
                end
            end
            default: ;
        endcase
    end

    // Entry and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data entries are plain flops, not a RAM, so clearing them is cheap and keeps m_data at 0 in reset.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout  = head_q;
    assign count = count_q;

endmodule

// File: rtl/fifo_drain.sv
// Drains a fifo_sync into a valid/ready stream. Reads are credit-limited so
// the 2-entry skid buffer can never overflow; with m_ready held high the
// block sustains one word per cycle.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_ren,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    drain_state_e      state_q, state_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [1:0]        buf_count;
    logic [DATA_W-1:0] buf_head;
    logic              handshake;

    // Word is consumed downstream when the buffer is non-empty and m_ready is high
    assign m_valid   = (buf_count != 2'd0);
    assign handshake = m_valid && m_ready;
    assign m_data    = buf_head;
    assign busy      = (state_q != IDLE);

    // Read only while running and enabled, with FIFO data available and a free credit;
    // dropping enable stops reads in the same cycle
    assign fifo_ren = (state_q == RUN) && enable && !fifo_empty &&
                      credit_avail(buf_count, inflight_q, handshake);

    // Words read at the previous edge are on fifo_data now and are captured at this edge
    skid_buf2 #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .din  (fifo_data),
        .pop  (handshake),
        .dout (buf_head),
        .count(buf_count)
    );

    // Controller next state, read tracking and handshake counting
    always_comb begin
        state_d    = state_q;
        inflight_d = fifo_ren;
        word_cnt_d = word_cnt_q + CNT_W'(handshake);

        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = STOP;
            end
            STOP: begin
                if (enable) begin
                    state_d = RUN;
                end else if (!inflight_q && (buf_count == 2'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers; reset drops any read still returning from the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: a queue-based fifo_sync stand-in, a transaction-level
// reference model compared every cycle, and directed scenarios pinned with
// hand-computed literals, followed by a randomized soak.
module tb_fifo_drain;
    import fifo_pkg::*;

    localparam int DW      = 32;
    localparam int CW      = 4;
    localparam int CNT_MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_ren;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          busy;
    logic [CW-1:0] word_cnt;

    fifo_drain #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_ren  (fifo_ren),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // fifo_sync stand-in contents
    logic [DW-1:0] fq[$];

    // Reference model: buffered words, word on its way from the FIFO, state, handshake count
    logic [DW-1:0] mq[$];
    bit            mpend = 1'b0;
    drain_state_e  mst = IDLE;
    int            mcnt = 0;
    bit            chk_en = 1'b0;

    // Activity logs for the directed scenarios
    int            cyc = 0;
    int            ren_log[$];
    int            first_valid = -1;
    logic [DW-1:0] hs_data[$];
    int            hs_cyc[$];

    bit p_hs, p_issue, e_valid, e_ren;
    int occ;

    always @(posedge rst) begin
        mq.delete();
        mpend = 1'b0;
        mst   = IDLE;
        mcnt  = 0;
    end

    // Edge-time bookkeeping: logs, model update and the fifo_sync read port
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            p_hs    = (mq.size() != 0) && m_ready;
            p_issue = fifo_ren && !fifo_empty;
            if (p_issue) ren_log.push_back(cyc);
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                hs_data.push_back(m_data);
                hs_cyc.push_back(cyc);
            end
            case (mst)
                IDLE:    if (enable) mst = RUN;
                RUN:     if (!enable) mst = STOP;
                default: if (enable) mst = RUN;
                         else if (!mpend && mq.size() == 0) mst = IDLE;
            endcase
            if (p_hs) begin
                void'(mq.pop_front());
                mcnt = (mcnt + 1) % CNT_MOD;
            end
            if (mpend) mq.push_back(fifo_data);
            mpend = p_issue;
            if (p_issue) fifo_data <= fq.pop_front();
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            e_valid = (mq.size() != 0);
            occ     = mq.size() + int'(mpend) - int'(e_valid && m_ready);
            e_ren   = (mst == RUN) && enable && !fifo_empty && (occ < 2);
            check("m_valid", m_valid, e_valid);
            if (e_valid) check("m_data", m_data, mq[0]);
            check("fifo_ren", fifo_ren, e_ren);
            check("busy", busy, mst != IDLE);
            check("word_cnt", word_cnt, mcnt);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_logs();
        ren_log.delete();
        hs_data.delete();
        hs_cyc.delete();
        first_valid = -1;
    endtask

    task automatic do_reset();
        tick();
        rst     = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
        chk_en = 1'b1;
    endtask

    task automatic wait_hs(input int n, input int budget, input string name);
        int k = 0;
        while (hs_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, hs_data.size() >= n, 1);
    endtask

    initial begin
        int n_issued;
        int k;

        // Basic stream: 10, 20, 30 back to back, 2-cycle latency
        do_reset();
        check("rst_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        push_word(32'd10);
        push_word(32'd20);
        push_word(32'd30);
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_hs(3, 20, "s1_wait");
        tick();
        tick();
        if (hs_data.size() >= 3) begin
            check("s1_d0", hs_data[0], 10);
            check("s1_d1", hs_data[1], 20);
            check("s1_d2", hs_data[2], 30);
            check("s1_gap01", hs_cyc[1] - hs_cyc[0], 1);
            check("s1_gap12", hs_cyc[2] - hs_cyc[1], 1);
        end
        if (ren_log.size() > 0) check("s1_latency", first_valid - ren_log[0], 2);
        check("s1_reads", ren_log.size(), 3);
        check("s1_cnt", word_cnt, 3);

        // Back-pressure: only two reads outstanding, then full drain in order
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        enable  = 1'b1;
        m_ready = 1'b0;
        repeat (10) tick();
        check("s2_reads", ren_log.size(), 2);
        check("s2_valid", m_valid, 1);
        check("s2_data", m_data, 1);
        m_ready = 1'b1;
        wait_hs(8, 40, "s2_wait");
        check("s2_count", hs_data.size(), 8);
        for (int i = 0; i < 8 && i < hs_data.size(); i++) check("s2_order", hs_data[i], i + 1);
        for (int i = 1; i < 8 && i < hs_cyc.size(); i++)
            check("s2_gap", (hs_cyc[i] - hs_cyc[i-1]) <= 2, 1);

        // m_ready toggling each cycle
        do_reset();
        for (int i = 0; i < 4; i++) push_word(DW'(1 << i));
        enable = 1'b1;
        for (int j = 0; j < 40; j++) begin
            m_ready = j[0];
            tick();
        end
        check("s3_count", hs_data.size(), 4);
        for (int i = 0; i < 4 && i < hs_data.size(); i++) check("s3_order", hs_data[i], 1 << i);

        // enable dropped mid-burst
        do_reset();
        for (int i = 0; i < 20; i++) push_word(DW'(100 + i));
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_hs(5, 30, "s4_wait");
        enable = 1'b0;
        #1;
        check("s4_ren_drop", fifo_ren, 0);
        n_issued = ren_log.size();
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        check("s4_idle", busy, 0);
        check("s4_valid", m_valid, 0);
        check("s4_no_new_reads", ren_log.size(), n_issued);
        check("s4_delivered", hs_data.size(), n_issued);
        check("s4_fifo_left", fq.size(), 20 - n_issued);
        check("s4_fifo_nonempty", fq.size() > 0, 1);

        // Reset with two words buffered
        do_reset();
        for (int i = 0; i < 10; i++) push_word(DW'(200 + i));
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_hs(2, 20, "s5_wait");
        m_ready = 1'b0;
        repeat (4) tick();
        check("s5_pre_valid", m_valid, 1);
        check("s5_pre_cnt_nz", word_cnt != 0, 1);
        n_issued = ren_log.size();
        rst = 1'b1;
        #1;
        check("s5_rst_valid", m_valid, 0);
        check("s5_rst_cnt", word_cnt, 0);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_ren", fifo_ren, 0);
        check("s5_rst_data", m_data, 0);
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_hs(1, 20, "s5_wait2");
        if (hs_data.size() > 0) check("s5_next_word", hs_data[0], 200 + n_issued);

        // word_cnt wrap at 2^CW - 1
        do_reset();
        for (int i = 0; i < 20; i++) push_word(DW'(300 + i));
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_hs(15, 40, "s6_wait");
        m_ready = 1'b0;
        check("s6_cnt_max", word_cnt, CNT_MOD - 1);
        tick();
        m_ready = 1'b1;
        tick();
        check("s6_cnt_wrap", word_cnt, 0);
        check("s6_hs16", hs_data.size(), 16);

        // Randomized soak with occasional enable toggles and asynchronous resets
        do_reset();
        enable = 1'b1;
        for (int j = 0; j < 3000; j++) begin
            if (fq.size() < 12 && $urandom_range(0, 9) < 6) push_word($urandom);
            m_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            tick();
        end
        enable  = 1'b0;
        m_ready = 1'b1;
        k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        check("soak_idle", busy, 0);
        check("soak_empty", m_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter DATA_W, default 32, width of the FIFO word and the stream word.
REQ-002 Parameter CNT_W, default 16, width of the delivered-word counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  level; 1 = drain the FIFO, 0 = stop issuing reads.
REQ-006 fifo_empty  input  1  empty flag from fifo_sync.
REQ-007 fifo_data  input  DATA_W  fifo_sync data_out; valid the cycle after a qualifying read edge.
REQ-008 fifo_ren  output  1  read enable to fifo_sync.
REQ-009 m_valid  output  1  stream word valid.
REQ-010 m_ready  input  1  downstream accepts the word when m_valid=1 and m_ready=1 at a rising edge.
REQ-011 m_data  output  DATA_W  stream word.
REQ-012 busy  output  1  1 in any state other than IDLE.
REQ-013 word_cnt  output  CNT_W  number of completed stream handshakes since reset.

Function
REQ-014 A read is issued when fifo_ren=1 and fifo_empty=0 at a rising edge; the word appears on fifo_data in the next cycle and is captured at the following edge.
REQ-015 fifo_ren is combinational and SHALL be 1 only when state=RUN, fifo_empty=0, and (buffered words + in-flight reads) < 2.
REQ-016 An internal 2-entry skid buffer SHALL hold captured words in FIFO order; m_data always presents the oldest entry; m_valid=1 if and only if the buffer is non-empty.
REQ-017 A capture and a handshake in the same cycle SHALL leave the occupancy unchanged, with no word lost, duplicated, or reordered.
REQ-018 The credit rule SHALL guarantee the buffer never overflows, so the block never drops a FIFO word.
REQ-019 With m_ready held at 1 and the FIFO non-empty, the block SHALL sustain one word per cycle after a 2-cycle initial latency (ren edge to m_valid).
REQ-020 m_valid, once asserted, SHALL remain asserted and m_data SHALL remain stable until the handshake completes.
REQ-021 The FSM SHALL have exactly three states: IDLE, RUN, and STOP.
REQ-022 Transition IDLE->RUN when enable=1.
REQ-023 Transition RUN->STOP when enable=0.
REQ-024 Transition STOP->RUN when enable=1.
REQ-025 Transition STOP->IDLE when no read is in flight and the buffer is empty.
REQ-026 In STOP, fifo_ren SHALL be 0, but in-flight words SHALL still be captured and delivered.
REQ-027 fifo_empty asserting while reads are in flight SHALL NOT cancel those reads.
REQ-028 word_cnt SHALL increment by 1 per handshake and wrap modulo 2^CNT_W.

Reset
REQ-029 On rst=1, immediately and independent of clk, the block SHALL force state=IDLE, buffer empty, in-flight=0, and word_cnt=0.
REQ-030 During reset the outputs SHALL be m_valid=0, m_data=0, fifo_ren=0, and busy=0.
REQ-031 A reset mid-transfer SHALL discard buffered and in-flight words; a word returning from the FIFO after reset release SHALL NOT be captured.

Structure
REQ-032 A shared package fifo_pkg SHALL hold the DATA_W default and the state enum type (IDLE, RUN, STOP), for reuse with fifo_sync.
REQ-033 A single sub-module, skid_buf2 (2-entry register buffer with push, pop, and count), SHALL be instantiated once.

Verification
REQ-034 Reset, write 10, 20, 30 to fifo_sync, enable=1, m_ready=1 -> m_data 10, 20, 30 on consecutive cycles, first m_valid 2 cycles after the first ren, word_cnt=3.
REQ-035 8 words 1..8 queued, m_ready=0 -> exactly 2 reads issued, m_valid=1 holding 1; then m_ready=1 -> 1..8 delivered in order with no gaps beyond 1 cycle.
REQ-036 Toggle m_ready every cycle with 4 words 2^0..2^3 -> each delivered exactly once, in order, with m_data stable while stalled.
REQ-037 enable drops during a streaming burst -> fifo_ren=0 immediately, in-flight words delivered, busy falls once the buffer is empty, remaining words stay in the FIFO.
REQ-038 rst asserted with 2 words buffered -> m_valid=0 and word_cnt=0 immediately; after release and enable, the next FIFO word is delivered first.
REQ-039 Force word_cnt to 2^CNT_W-1, complete 1 handshake -> word_cnt=0.
